// File: rtl/pio_pkg.sv
// Shared register map and edge-type encodings for the Avalon PIO slave.
package pio_pkg;

  localparam logic [2:0] REG_DATA    = 3'd0;
  localparam logic [2:0] REG_DIR     = 3'd1;
  localparam logic [2:0] REG_IRQMASK = 3'd2;
  localparam logic [2:0] REG_EDGECAP = 3'd3;
  localparam logic [2:0] REG_OUTSET  = 3'd4;
  localparam logic [2:0] REG_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/avalon_pio_irq_if.sv
// Avalon-MM slave bus bundle for the PIO block (3-bit word address, 32-bit data).
interface avalon_pio_irq_if;
  // Handshake: a write is chipselect & ~write_n and commits on the next clk edge;
  // reads are combinational with zero wait states, so there is no waitrequest.
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_sync_edge.sv
// Input synchroniser chain, one-cycle delay flop and per-bit edge detector.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_det
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] dly_q;
  logic [WIDTH-1:0] dly_d;

  always_comb begin
    sync_d[0] = in_port;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    dly_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      dly_q <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      dly_q <= dly_d;
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];

  // Detection looks at every bit, including those currently driven as outputs.
  always_comb begin
    edge_det = in_sync & ~dly_q;
    case (EDGE_TYPE)
      EDGE_FALL: edge_det = ~in_sync & dly_q;
      EDGE_ANY:  edge_det = in_sync ^ dly_q;
      default:   ;
    endcase
  end

endmodule

// File: rtl/avalon_pio_irq.sv
// Avalon-MM PIO slave with direction, edge capture and maskable level irq.
// Optional bit set/clear registers at addresses 4/5 enabled by `define PIO_BIT_SETCLR_EN.
module avalon_pio_irq
  import pio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter logic [31:0] DIR_RESET   = 32'hFFFF_FFFF,
  parameter int          EDGE_TYPE   = EDGE_RISE,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  avalon_pio_irq_if.slave   bus,
  input  logic [WIDTH-1:0]  in_port,
  output logic [WIDTH-1:0]  out_port,
  output logic [WIDTH-1:0]  oe,
  output logic              irq
);

  localparam logic [WIDTH-1:0] DATA_RST = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] DIR_RST  = DIR_RESET[WIDTH-1:0];

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd_val;
  logic [31:0]      rdata;
  logic             wr;
  logic             wr_edgecap;
  logic             unused_wd;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .in_sync  (in_sync),
    .edge_det (edge_det)
  );

  assign wr         = bus.chipselect & ~bus.write_n;
  assign wd         = bus.writedata[WIDTH-1:0];
  assign wr_edgecap = wr && (bus.address == REG_EDGECAP);
  assign unused_wd  = ^bus.writedata;

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irqmask_d  = irqmask_q;
    if (wr) begin
      case (bus.address)
        REG_DATA:    data_out_d = wd;
        REG_DIR:     dir_d      = wd;
        REG_IRQMASK: irqmask_d  = wd;
`ifdef PIO_BIT_SETCLR_EN
        REG_OUTSET:  data_out_d = data_out_q | wd;
        REG_OUTCLR:  data_out_d = data_out_q & ~wd;
`endif
        default:     ;
      endcase
    end
    // A new edge outranks a write-1-to-clear landing in the same cycle.
    edgecap_d = edge_det | (edgecap_q & ~({WIDTH{wr_edgecap}} & wd));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= DATA_RST;
      dir_q      <= DIR_RST;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
    end
  end

  always_comb begin
    rd_val = '0;
    if (bus.chipselect) begin
      case (bus.address)
        REG_DATA:               rd_val = (dir_q & data_out_q) | (~dir_q & in_sync);
        REG_DIR:                rd_val = dir_q;
        REG_IRQMASK:            rd_val = irqmask_q;
        REG_EDGECAP:            rd_val = edgecap_q;
        REG_OUTSET, REG_OUTCLR: rd_val = '0;
        default:                rd_val = '0;
      endcase
    end
    rdata              = '0;
    rdata[WIDTH-1:0]   = rd_val;
  end

  assign bus.readdata = rdata;
  assign out_port     = data_out_q;
  assign oe           = dir_q;
  assign irq          = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_avalon_pio_irq.sv
// Directed bench for avalon_pio_irq (WIDTH=8, rising-edge capture, 2-stage sync).
module tb_avalon_pio_irq;

  logic       clk;
  logic       reset_n;
  logic [7:0] in_port;
  logic [7:0] out_port;
  logic [7:0] oe;
  logic       irq;
  int         n_checks;
  int         n_fail;
  logic [31:0] rd;

  avalon_pio_irq_if bus ();

  avalon_pio_irq #(
    .WIDTH       (8),
    .RESET_VALUE (32'h0),
    .DIR_RESET   (32'hFFFF_FFFF),
    .EDGE_TYPE   (0),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .in_port  (in_port),
    .out_port (out_port),
    .oe       (oe),
    .irq      (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    #1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset_n        = 1'b0;
    in_port        = 8'h00;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    wait_clks(3);
    reset_n = 1'b1;
    #1;

    // Reset state
    bus_read(3'd0, rd); check_eq("rst_data", rd, 32'h00);
    bus_read(3'd1, rd); check_eq("rst_dir", rd, 32'hFF);
    bus_read(3'd2, rd); check_eq("rst_mask", rd, 32'h00);
    bus_read(3'd3, rd); check_eq("rst_edgecap", rd, 32'h00);
    check_eq("rst_out_port", {24'h0, out_port}, 32'h00);
    check_eq("rst_oe", {24'h0, oe}, 32'hFF);
    check_eq("rst_irq", {31'h0, irq}, 32'h0);

    // Data write, upper bits of writedata dropped
    bus_write(3'd0, 32'h1A5);
    check_eq("out_port_a5", {24'h0, out_port}, 32'hA5);
    bus_read(3'd0, rd); check_eq("rd_data_a5", rd, 32'hA5);

    // Mixed direction readback
    bus_write(3'd1, 32'h0F);
    check_eq("oe_0f", {24'h0, oe}, 32'h0F);
    in_port = 8'hC3;
    wait_clks(3);
    bus_read(3'd0, rd); check_eq("rd_data_mixed", rd, 32'hC5);
    bus_read(3'd3, rd); check_eq("edgecap_c3", rd, 32'hC3);
    check_eq("irq_masked_c3", {31'h0, irq}, 32'h0);
    bus_write(3'd3, 32'hFF);
    bus_read(3'd3, rd); check_eq("edgecap_clr_all", rd, 32'h00);

    // Falling edges ignored in rising mode
    in_port = 8'h00;
    wait_clks(4);
    bus_read(3'd3, rd); check_eq("fall_ignored", rd, 32'h00);

    // Rising edge on bit 0 with mask
    bus_write(3'd2, 32'h01);
    bus_read(3'd2, rd); check_eq("mask_rd", rd, 32'h01);
    in_port = 8'h01;
    wait_clks(1);
    bus_read(3'd3, rd); check_eq("edgecap_early", rd, 32'h00);
    wait_clks(2);
    bus_read(3'd3, rd); check_eq("edgecap_set", rd, 32'h01);
    check_eq("irq_set", {31'h0, irq}, 32'h1);
    bus_write(3'd3, 32'h01);
    bus_read(3'd3, rd); check_eq("edgecap_clr", rd, 32'h00);
    check_eq("irq_clr", {31'h0, irq}, 32'h0);

    // Pending edge while masked, then unmask
    bus_write(3'd2, 32'h00);
    in_port = 8'h00;
    wait_clks(4);
    in_port = 8'h01;
    wait_clks(4);
    bus_read(3'd3, rd); check_eq("edgecap_pending", rd, 32'h01);
    check_eq("irq_pending_masked", {31'h0, irq}, 32'h0);
    bus_write(3'd2, 32'h01);
    check_eq("irq_unmask", {31'h0, irq}, 32'h1);

    // Clear write colliding with a new rising edge: set wins
    in_port = 8'h00;
    wait_clks(4);
    in_port = 8'h01;
    wait_clks(2);
    bus.address    = 3'd3;
    bus.writedata  = 32'h01;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    #1;
    bus_read(3'd3, rd); check_eq("collide_edgecap", rd, 32'h01);
    check_eq("collide_irq", {31'h0, irq}, 32'h1);

    // Set/clear aliases
    bus_write(3'd0, 32'h0F);
    bus_write(3'd4, 32'h30);
`ifdef PIO_BIT_SETCLR_EN
    check_eq("outset", {24'h0, out_port}, 32'h3F);
`else
    check_eq("outset", {24'h0, out_port}, 32'h0F);
`endif
    bus_write(3'd5, 32'h03);
`ifdef PIO_BIT_SETCLR_EN
    check_eq("outclr", {24'h0, out_port}, 32'h3C);
`else
    check_eq("outclr", {24'h0, out_port}, 32'h0F);
`endif
    bus_read(3'd4, rd); check_eq("rd_addr4", rd, 32'h00);
    bus_read(3'd5, rd); check_eq("rd_addr5", rd, 32'h00);

    // Reserved addresses and deselected read
    bus_write(3'd6, 32'hFF);
    bus_write(3'd7, 32'hFF);
    check_eq("rsvd_oe", {24'h0, oe}, 32'h0F);
    bus_read(3'd6, rd); check_eq("rd_addr6", rd, 32'h00);
    bus_read(3'd7, rd); check_eq("rd_addr7", rd, 32'h00);
    bus.address = 3'd1;
    #1;
    check_eq("rd_no_cs", bus.readdata, 32'h00);

    // Asynchronous reset mid-operation, irq currently high
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_out_port", {24'h0, out_port}, 32'h00);
    check_eq("arst_oe", {24'h0, oe}, 32'hFF);
    check_eq("arst_irq", {31'h0, irq}, 32'h0);
    wait_clks(2);
    reset_n = 1'b1;
    #1;
    bus_read(3'd2, rd); check_eq("arst_mask", rd, 32'h00);
    bus_read(3'd3, rd); check_eq("arst_edgecap", rd, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
